hsl_to_rgb_pipe: RTL and testbench

Four-stage pipelined HSL-to-RGB converter that sits directly downstream of the RGB-to-HSL stage. It accepts one HSL pixel per cycle in the same encoding that stage produces: h 0..359, s 0..255, l 0..255. It emits 8-bit R, G and B under a valid/ready handshake with whole-pipeline stall. It closes the colour-space round trip so HSL-domain processing can be written back as RGB, and so the converter pair can be checked against each other.

---
 rtl/hsl_to_rgb_pipe.sv | 185 ++++++++++++++++++
 tb/tb_hsl_to_rgb_pipe.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsl_to_rgb_pipe.sv
// hsl_to_rgb_pipe: four-stage HSL -> RGB converter (h 0..359, s/l 0..255).
// One pixel per cycle under valid/ready; any output stall freezes every stage.
module hsl_to_rgb_pipe (
    input  logic       Clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] h_in,
    input  logic [7:0] s_in,
    input  logic [7:0] l_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out
);

    // Whole-pipeline advance: only a held, unconsumed output blocks progress.
    logic adv;

    // Stage 1 registers
    logic       s1_valid_q;
    logic [2:0] s1_sector_q;
    logic [5:0] s1_f_q;
    logic [7:0] s1_a_q, s1_s_q, s1_l_q;
    // Stage 2 registers
    logic       s2_valid_q;
    logic [2:0] s2_sector_q;
    logic [5:0] s2_f_q;
    logic [7:0] s2_c_q, s2_l_q;
    // Stage 3 registers
    logic       s3_valid_q;
    logic [2:0] s3_sector_q;
    logic [7:0] s3_c_q, s3_x_q, s3_m_q;
    // Stage 4 (output) registers
    logic       s4_valid_q;
    logic [7:0] r_q, g_q, b_q;

    // Combinational next-state values
    logic [8:0]  h_fix, s1_base;
    logic [2:0]  s1_sector_d;
    logic [5:0]  s1_f_d;
    logic [7:0]  s1_a_d;
    logic [15:0] s2_prod;
    logic [7:0]  s2_c_d;
    logic [5:0]  s3_w;
    logic [13:0] s3_prod;
    logic [7:0]  s3_x_d, s3_m_d;
    logic [7:0]  rp, gp, bp;
    logic [7:0]  r_d, g_d, b_d;

    assign adv       = !s4_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = s4_valid_q;
    assign r_out     = r_q;
    assign g_out     = g_q;
    assign b_out     = b_q;

    // Adds the offset m to a channel, saturating at 255.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Stage 1 logic: clamp hue, split into sector/offset, compute chroma scale a.
    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path can infer a latch.
        s1_sector_d = 3'd5;
        s1_base     = 9'd300;
        h_fix       = (h_in > 9'd359) ? 9'd0 : h_in;
        if (h_fix < 9'd60) begin
            s1_sector_d = 3'd0; s1_base = 9'd0;
        end else if (h_fix < 9'd120) begin
            s1_sector_d = 3'd1; s1_base = 9'd60;
        end else if (h_fix < 9'd180) begin
            s1_sector_d = 3'd2; s1_base = 9'd120;
        end else if (h_fix < 9'd240) begin
            s1_sector_d = 3'd3; s1_base = 9'd180;
        end else if (h_fix < 9'd300) begin
            s1_sector_d = 3'd4; s1_base = 9'd240;
        end
        s1_f_d = 6'(h_fix - s1_base);
        // a = 255 - |2l - 255| folds to 2l below the midpoint and 510 - 2l above it.
        if (l_in[7]) s1_a_d = 8'(9'd510 - {l_in, 1'b0});
        else         s1_a_d = {l_in[6:0], 1'b0};
    end

    // Stage 1 registers: capture the decoded input pixel.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset as well, so every output reads 0 rather than X after reset.
            s1_valid_q  <= 1'b0;
            s1_sector_q <= '0;
            s1_f_q      <= '0;
            s1_a_q      <= '0;
            s1_s_q      <= '0;
            s1_l_q      <= '0;
        end else if (adv) begin
            // NOTE: non-blocking so each stage samples the previous stage's value from before the edge.
            s1_valid_q  <= in_valid;
            s1_sector_q <= s1_sector_d;
            s1_f_q      <= s1_f_d;
            s1_a_q      <= s1_a_d;
            s1_s_q      <= s_in;
            s1_l_q      <= l_in;
        end
    end

    // Stage 2 logic: chroma C = floor(a*s/255); constant divisor keeps the floor exact.
    assign s2_prod = {8'd0, s1_a_q} * {8'd0, s1_s_q};
    assign s2_c_d  = 8'(s2_prod / 16'd255);

    // Stage 2 registers: chroma plus the fields later stages still need.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            s2_valid_q  <= 1'b0;
            s2_sector_q <= '0;
            s2_f_q      <= '0;
            s2_c_q      <= '0;
            s2_l_q      <= '0;
        end else if (adv) begin
            s2_valid_q  <= s1_valid_q;
            s2_sector_q <= s1_sector_q;
            s2_f_q      <= s1_f_q;
            s2_c_q      <= s2_c_d;
            s2_l_q      <= s1_l_q;
        end
    end

    // Stage 3 logic: secondary component X and lightness offset m.
    assign s3_w    = s2_sector_q[0] ? (6'd60 - s2_f_q) : s2_f_q;
    assign s3_prod = {6'd0, s2_c_q} * {8'd0, s3_w};
    assign s3_x_d  = 8'(s3_prod / 14'd60);
    assign s3_m_d  = s2_l_q - {1'b0, s2_c_q[7:1]};

    // Stage 3 registers: C, X, m and the sector for the final permutation.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            s3_valid_q  <= 1'b0;
            s3_sector_q <= '0;
            s3_c_q      <= '0;
            s3_x_q      <= '0;
            s3_m_q      <= '0;
        end else if (adv) begin
            s3_valid_q  <= s2_valid_q;
            s3_sector_q <= s2_sector_q;
            s3_c_q      <= s2_c_q;
            s3_x_q      <= s3_x_d;
            s3_m_q      <= s3_m_d;
        end
    end

    // Stage 4 logic: place C and X by sector, then add m with saturation.
    always_comb begin
        rp = s3_c_q; gp = 8'd0; bp = s3_x_q;
        case (s3_sector_q)
            3'd0:    begin rp = s3_c_q; gp = s3_x_q; bp = 8'd0;   end
            3'd1:    begin rp = s3_x_q; gp = s3_c_q; bp = 8'd0;   end
            3'd2:    begin rp = 8'd0;   gp = s3_c_q; bp = s3_x_q; end
            3'd3:    begin rp = 8'd0;   gp = s3_x_q; bp = s3_c_q; end
            3'd4:    begin rp = s3_x_q; gp = 8'd0;   bp = s3_c_q; end
            default: begin rp = s3_c_q; gp = 8'd0;   bp = s3_x_q; end
        endcase
        r_d = sat_add(rp, s3_m_q);
        g_d = sat_add(gp, s3_m_q);
        b_d = sat_add(bp, s3_m_q);
    end

    // Stage 4 registers: the visible output pixel, held while stalled.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            s4_valid_q <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else if (adv) begin
            s4_valid_q <= s3_valid_q;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

endmodule

// File: tb/tb_hsl_to_rgb_pipe.sv
// tb_hsl_to_rgb_pipe: directed checks of hsl_to_rgb_pipe with hand-computed results.
// Inputs change and outputs are sampled one time unit after each rising edge.
module tb_hsl_to_rgb_pipe;

    logic       Clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] h_in = '0;
    logic [7:0] s_in = '0;
    logic [7:0] l_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] r_out, g_out, b_out;

    int total = 0;
    int bad   = 0;

    // Stimulus vectors, expected results, and what the stream driver collected.
    logic [8:0]  vh[$];
    logic [7:0]  vs[$];
    logic [7:0]  vl[$];
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    int          got_cyc[$];
    logic        stall_ir[$];
    logic        stall_ov[$];
    logic [23:0] stall_rgb[$];
    int          stall_idx[$];

    always #5 Clk = ~Clk;

    hsl_to_rgb_pipe dut (
        .Clk       (Clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h_in      (h_in),
        .s_in      (s_in),
        .l_in      (l_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_vectors();
        vh.delete(); vs.delete(); vl.delete(); exp_q.delete();
    endtask

    task automatic add_vec(input int h, input int s, input int l, input int r, input int g, input int b);
        vh.push_back(9'(h));
        vs.push_back(8'(s));
        vl.push_back(8'(l));
        exp_q.push_back({8'(r), 8'(g), 8'(b)});
    endtask

    // Streams all queued vectors, holding out_ready low for stall_len cycles from stall_at.
    // Records every output transfer and a snapshot of each stalled cycle; cycle budget bounded.
    task automatic run_stream(input int stall_at, input int stall_len);
        int   n, idx, cyc;
        logic acc_in;
        n = vh.size(); idx = 0; cyc = 0;
        got_q.delete(); got_cyc.delete();
        stall_ir.delete(); stall_ov.delete(); stall_rgb.delete(); stall_idx.delete();
        while ((idx < n || got_q.size() < n) && cyc < n + 64) begin
            if (idx < n) begin
                in_valid = 1'b1; h_in = vh[idx]; s_in = vs[idx]; l_in = vl[idx];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            #1;
            acc_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got_q.push_back({r_out, g_out, b_out});
                got_cyc.push_back(cyc);
            end
            if (!out_ready) begin
                stall_ir.push_back(in_ready);
                stall_ov.push_back(out_valid);
                stall_rgb.push_back({r_out, g_out, b_out});
                stall_idx.push_back(got_q.size());
            end
            step();
            if (acc_in) idx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    // Compares the collected stream against exp_q element by element.
    task automatic compare_stream(input string name);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL %s_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s[%0d] got=%h want=%h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            h_in = 9'($urandom); s_in = 8'($urandom); l_in = 8'($urandom);
            #2;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
            total++;
            if ({r_out, g_out, b_out} !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h want=000000", {r_out, g_out, b_out}); end
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        rst = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
        // Accepted at the next edge k; the result is presented to edge k+4.
        in_valid = 1'b1; h_in = 9'd0; s_in = 8'd255; l_in = 8'd127;
        step();
        in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early edge=%0d got=%b want=0", e, out_valid); end
            step();
        end
        total++;
        if (out_valid !== 1'b1 || {r_out, g_out, b_out} !== {8'd254, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL latency_first got=%b/%h want=1/fe0000", out_valid, {r_out, g_out, b_out});
        end
        step();
    endtask

    task automatic test_hue_sectors();
        clear_vectors();
        add_vec( 30, 255, 127, 254, 127,   0);
        add_vec( 60, 255, 127, 254, 254,   0);
        add_vec(120, 255, 127,   0, 254,   0);
        add_vec(240, 255, 127,   0,   0, 254);
        add_vec(400, 255, 127, 254,   0,   0);
        add_vec( 90, 255, 127, 127, 254,   0);
        add_vec(359, 255, 127, 254,   0,   4);
        add_vec(360, 255, 127, 254,   0,   0);
        run_stream(1 << 30, 0);
        compare_stream("hue");
        for (int i = 1; i < got_cyc.size(); i++) begin
            total++;
            if (got_cyc[i] !== got_cyc[0] + i) begin
                bad++;
                $display("FAIL hue_rate[%0d] cycle=%0d want=%0d", i, got_cyc[i], got_cyc[0] + i);
            end
        end
    endtask

    task automatic test_lightness();
        clear_vectors();
        add_vec(200,   0, 100, 100, 100, 100);
        add_vec(  0, 255, 255, 255, 255, 255);
        add_vec(  0, 255,   0,   0,   0,   0);
        add_vec(  0, 255, 128, 255,   1,   1);
        add_vec(  0, 128,  64,  96,  32,  32);
        run_stream(1 << 30, 0);
        compare_stream("light");
    endtask

    task automatic test_backpressure();
        clear_vectors();
        add_vec(180, 255, 127,   0, 254, 254);
        add_vec(300, 255, 127, 254,   0, 254);
        add_vec( 90, 255, 127, 127, 254,   0);
        add_vec(330, 255, 127, 254,   0, 127);
        add_vec(210, 255, 127,   0, 127, 254);
        add_vec(150, 255, 127,   0, 254, 127);
        add_vec(359, 255, 127, 254,   0,   4);
        add_vec(  0, 128,  64,  96,  32,  32);
        add_vec(200,   0, 100, 100, 100, 100);
        add_vec(  0, 255, 128, 255,   1,   1);
        run_stream(6, 5);
        compare_stream("bp");
        total++;
        if (stall_ir.size() !== 5) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=5", stall_ir.size()); end
        for (int i = 0; i < stall_ir.size(); i++) begin
            total++;
            if (stall_ir[i] !== 1'b0 || stall_ov[i] !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d] in_ready=%b out_valid=%b want 0/1", i, stall_ir[i], stall_ov[i]);
            end
            total++;
            if (stall_idx[i] < exp_q.size() && stall_rgb[i] !== exp_q[stall_idx[i]]) begin
                bad++;
                $display("FAIL bp_frozen[%0d] got=%h want=%h", i, stall_rgb[i], exp_q[stall_idx[i]]);
            end
        end
    endtask

    task automatic test_bubbles();
        logic pat[14];
        logic ov[14];
        for (int c = 0; c < 14; c++) begin
            pat[c]    = (c < 10) && (c % 2 == 0);
            in_valid  = pat[c];
            h_in = 9'd30; s_in = 8'd255; l_in = 8'd127;
            out_ready = 1'b1;
            #1;
            ov[c] = out_valid;
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 14; c++) begin
            logic want;
            want = (c >= 4) ? pat[c - 4] : 1'b0;
            total++;
            if (ov[c] !== want) begin
                bad++;
                $display("FAIL bubble[%0d] out_valid=%b want=%b", c, ov[c], want);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int stale;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; h_in = 9'(60 * c); s_in = 8'd255; l_in = 8'd127;
            out_ready = 1'b1;
            step();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_reset out_valid=%b want=1", out_valid); end
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || {r_out, g_out, b_out} !== 24'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h/%b want=0/000000/1", out_valid, {r_out, g_out, b_out}, in_ready);
        end
        step();
        step();
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid !== 1'b0) stale++;
            step();
        end
        total++;
        if (stale !== 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", stale); end
        in_valid = 1'b1; h_in = 9'd120; s_in = 8'd255; l_in = 8'd127;
        step();
        in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_latency_early edge=%0d got=%b want=0", e, out_valid); end
            step();
        end
        total++;
        if (out_valid !== 1'b1 || {r_out, g_out, b_out} !== {8'd0, 8'd254, 8'd0}) begin
            bad++;
            $display("FAIL mid_latency got=%b/%h want=1/00fe00", out_valid, {r_out, g_out, b_out});
        end
        step();
    endtask

    // Bench model of the upstream RGB-to-HSL stage: chroma-preserving saturation,
    // lightness rounded toward mid-grey, hue rounded to the nearest degree.
    function automatic void rgb_to_hsl(input int r, input int g, input int b,
                                       output int h, output int s, output int l);
        int  mx, mn, d, sum, a;
        real hr;
        mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
        mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
        d = mx - mn; sum = mx + mn;
        l = (sum < 255) ? (sum + 1) / 2 : sum / 2;
        a = (l < 128) ? 2 * l : 510 - 2 * l;
        if (d == 0 || a == 0) s = 0;
        else begin
            s = (d * 255 + a - 1) / a;
            if (s > 255) s = 255;
        end
        if (d == 0) h = 0;
        else begin
            if (mx == r)      hr = 60.0 * (g - b) / d;
            else if (mx == g) hr = 120.0 + 60.0 * (b - r) / d;
            else              hr = 240.0 + 60.0 * (r - g) / d;
            if (hr < 0.0) hr = hr + 360.0;
            h = $rtoi(hr + 0.5);
            if (h >= 360) h = h - 360;
        end
    endfunction

    task automatic test_round_trip();
        int h, s, l;
        clear_vectors();
        for (int r = 0; r < 16; r++)
            for (int g = 0; g < 16; g++)
                for (int b = 0; b < 16; b++) begin
                    rgb_to_hsl(17 * r, 17 * g, 17 * b, h, s, l);
                    add_vec(h, s, l, 17 * r, 17 * g, 17 * b);
                end
        run_stream(1 << 30, 0);
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rt_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            int worst, diff;
            worst = 0;
            for (int ch = 0; ch < 3; ch++) begin
                int gv, ev;
                gv = 32'(got_q[i][8 * ch +: 8]);
                ev = 32'(exp_q[i][8 * ch +: 8]);
                diff = (gv > ev) ? gv - ev : ev - gv;
                if (diff > worst) worst = diff;
            end
            total++;
            if (worst > 2) begin
                bad++;
                $display("FAIL rt[%0d] got=%h want=%h (+-2)", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_hue_sectors();
        test_lightness();
        test_backpressure();
        test_bubbles();
        test_reset_midstream();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
